// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline MEM stage: preloaded word RAM behind valid/ready
// request/response channels with a programmable response latency. Option: DMEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = DEPTH;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  count;
   logic        accept;
   logic        commit;
   logic        release_rsp;

   logic        cap_we;
   logic [29:0] cap_word;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_misaligned;
   logic        out_of_range;
   logic        access_err;
   logic [AW-1:0] word_idx;

   // Power-up image; reset deliberately leaves the array alone.
   logic [31:0] mem [DEPTH] = '{0: 32'hDEADBEEF, 1: 32'h12345678, 3: 32'hFEDCBA98, default: 32'h0};

   assign out_of_range = ({2'b00, cap_word} >= DEPTH_W);
   assign access_err   = cap_misaligned || out_of_range;
   assign word_idx     = cap_word[AW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      commit      = 1'b0;
      release_rsp = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept     = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (count == 4'd0) begin
               commit     = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               release_rsp = 1'b1;
               next_state  = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // req_ready is registered so it reads 0 during reset and rises one edge after entering IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_ready <= 1'b0;
         count     <= 4'd0;
      end else begin
         req_ready <= (next_state == IDLE);
         if (accept) begin
            count <= CNT_INIT;
         end else if (state == WAIT && count != 4'd0) begin
            count <= count - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_we    <= 1'b0;
         cap_word  <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else if (accept) begin
         cap_we    <= req_we;
         cap_word  <= req_addr[31:2];
         cap_wdata <= req_wdata;
         cap_be    <= req_be;
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_misaligned <= 1'b0;
      end else if (accept) begin
         cap_misaligned <= (req_addr[1:0] != 2'b00);
      end
   end
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];
   assign cap_misaligned  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (commit) begin
         rsp_valid <= 1'b1;
         rsp_err   <= access_err;
         rsp_rdata <= (!cap_we && !access_err) ? mem[word_idx] : 32'h0;
      end else if (release_rsp) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end
   end

   // Stores land on the WAIT->RESP edge, so a reset during WAIT never commits them.
   always_ff @(posedge clk) begin
      if (commit && cap_we && !access_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cap_be[b]) begin
               mem[word_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
